comb_lock_ctrl: RTL and testbench

COMB_LOCK_CTRL -- requirements
Module: comb_lock_ctrl

---
 rtl/comb_lock_ctrl.sv | 139 +++++++++++++
 tb/tb_comb_lock_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_lock_ctrl.sv
// Combination lock controller: edge-detected submit, wrong-entry counting, timed
// lockout, and a two-step change sequence that strobes the external code register.
module comb_lock_ctrl #(
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       Resetn,
    input  logic [3:0] combo,
    input  logic [3:0] entry,
    input  logic       enter,
    input  logic       change_req,
    output logic       unlocked,
    output logic       alarm,
    output logic       set_out,
    output logic [3:0] new_code,
    output logic [2:0] tries_left,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_LOCKED     = 3'd0,
        S_UNLOCKED   = 3'd1,
        S_LOCKOUT    = 3'd2,
        S_CHG_SETUP  = 3'd3,
        S_CHG_STROBE = 3'd4
    } state_t;

    localparam logic [2:0]  TRIES_MAX  = 3'(MAX_TRIES);
    localparam logic [15:0] TIMER_LOAD = 16'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]  CODE_RST   = 4'b0110;

    state_t      state_q, state_d;
    logic        enter_q, enter_d;
    logic        unlocked_q, unlocked_d;
    logic        alarm_q, alarm_d;
    logic        set_out_q, set_out_d;
    logic [3:0]  new_code_q, new_code_d;
    logic [2:0]  tries_left_q, tries_left_d;
    logic [15:0] timer_q, timer_d;
    logic        submit;

    // A held enter level yields one submit; enter_q clears on reset so a level
    // held across reset release still counts once.
    assign submit = enter & ~enter_q;

    always_comb begin
        state_d      = state_q;
        enter_d      = enter;
        unlocked_d   = unlocked_q;
        alarm_d      = alarm_q;
        set_out_d    = 1'b0;
        new_code_d   = new_code_q;
        tries_left_d = tries_left_q;
        timer_d      = timer_q;

        case (state_q)
            S_LOCKED: begin
                if (submit) begin
                    if (entry == combo) begin
                        state_d      = S_UNLOCKED;
                        unlocked_d   = 1'b1;
                        tries_left_d = TRIES_MAX;
                    end else if (tries_left_q > 3'd1) begin
                        tries_left_d = tries_left_q - 3'd1;
                    end else begin
                        state_d      = S_LOCKOUT;
                        alarm_d      = 1'b1;
                        tries_left_d = 3'd0;
                        timer_d      = TIMER_LOAD;
                    end
                end
            end
            S_LOCKOUT: begin
                if (timer_q == 16'd0) begin
                    state_d      = S_LOCKED;
                    alarm_d      = 1'b0;
                    tries_left_d = TRIES_MAX;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_UNLOCKED: begin
                if (submit) begin
                    if (change_req) begin
                        new_code_d = entry;
                        state_d    = S_CHG_SETUP;
                    end else begin
                        state_d    = S_LOCKED;
                        unlocked_d = 1'b0;
                    end
                end
            end
            // new_code is already stable here, giving the storage register setup time.
            S_CHG_SETUP: begin
                state_d   = S_CHG_STROBE;
                set_out_d = 1'b1;
            end
            S_CHG_STROBE: begin
                state_d = S_UNLOCKED;
            end
            default: begin
                state_d    = S_LOCKED;
                unlocked_d = 1'b0;
                alarm_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= S_LOCKED;
            enter_q      <= 1'b0;
            unlocked_q   <= 1'b0;
            alarm_q      <= 1'b0;
            set_out_q    <= 1'b0;
            new_code_q   <= CODE_RST;
            tries_left_q <= TRIES_MAX;
            timer_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            enter_q      <= enter_d;
            unlocked_q   <= unlocked_d;
            alarm_q      <= alarm_d;
            set_out_q    <= set_out_d;
            new_code_q   <= new_code_d;
            tries_left_q <= tries_left_d;
            timer_q      <= timer_d;
        end
    end

    assign unlocked   = unlocked_q;
    assign alarm      = alarm_q;
    assign set_out    = set_out_q;
    assign new_code   = new_code_q;
    assign tries_left = tries_left_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_comb_lock_ctrl.sv
// Bench for comb_lock_ctrl: scenario tasks with inline checks, plus a cycle model
// feeding an expected queue that is compared against the outputs every cycle.
`timescale 1ns/1ps
module tb_comb_lock_ctrl;

    localparam int MAX_TRIES      = 3;
    localparam int LOCKOUT_CYCLES = 16;

    logic       clk = 1'b0;
    logic       Resetn = 1'b1;
    logic [3:0] combo;
    logic [3:0] entry = 4'd0;
    logic       enter = 1'b0;
    logic       change_req = 1'b0;
    logic       unlocked, alarm, set_out;
    logic [3:0] new_code;
    logic [2:0] tries_left, dbg_state;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    comb_lock_ctrl #(.MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)) dut (
        .clk(clk), .Resetn(Resetn), .combo(combo), .entry(entry), .enter(enter),
        .change_req(change_req), .unlocked(unlocked), .alarm(alarm), .set_out(set_out),
        .new_code(new_code), .tries_left(tries_left), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // External combination storage register loaded by set_out.
    always @(posedge set_out or negedge Resetn) begin
        if (!Resetn) combo <= 4'b0110;
        else         combo <= new_code;
    end

    // Cycle model: predicts {unlocked, alarm, set_out, tries_left, new_code}.
    typedef enum int {M_LOCKED, M_UNLOCKED, M_LOCKOUT, M_SETUP, M_STROBE} mstate_t;
    mstate_t    m_state;
    int         m_tries, m_left;
    logic [3:0] m_code;
    logic       m_prev, m_sub;
    logic [9:0] exp_q[$];
    logic [9:0] exp_w, got_w;

    always @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            m_state = M_LOCKED; m_tries = MAX_TRIES; m_left = 0;
            m_code = 4'b0110; m_prev = 1'b0;
            exp_q.delete();
        end else begin
            m_sub  = enter && !m_prev;
            m_prev = enter;
            case (m_state)
                M_LOCKED: if (m_sub) begin
                    if (entry == combo) begin m_state = M_UNLOCKED; m_tries = MAX_TRIES; end
                    else if (m_tries > 1) m_tries = m_tries - 1;
                    else begin m_state = M_LOCKOUT; m_tries = 0; m_left = LOCKOUT_CYCLES; end
                end
                M_LOCKOUT: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_state = M_LOCKED; m_tries = MAX_TRIES; end
                end
                M_UNLOCKED: if (m_sub) begin
                    if (change_req) begin m_code = entry; m_state = M_SETUP; end
                    else m_state = M_LOCKED;
                end
                M_SETUP:  m_state = M_STROBE;
                M_STROBE: m_state = M_UNLOCKED;
                default:  m_state = M_LOCKED;
            endcase
            exp_q.push_back({m_state inside {M_UNLOCKED, M_SETUP, M_STROBE},
                             m_state == M_LOCKOUT, m_state == M_STROBE,
                             3'(m_tries), m_code});
        end
    end

    always @(negedge clk) begin
        if (Resetn && exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            got_w = {unlocked, alarm, set_out, tries_left, new_code};
            chk_cnt++;
            if (got_w !== exp_w)
                $display("FAIL scoreboard t=%0t: got %b required %b", $time, got_w, exp_w);
            else pass_cnt++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise enter for one clock; on return the submit edge has just been taken.
    task automatic submit(input logic [3:0] e, input logic cr);
        entry = e; change_req = cr; enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic test_reset();
        #2 Resetn = 1'b0;
        #1;
        chk_cnt++;
        if ({unlocked, alarm, set_out, tries_left, new_code, dbg_state} !== {3'b000, 3'd3, 4'b0110, 3'd0})
            $display("FAIL reset_values: got %b required %b",
                     {unlocked, alarm, set_out, tries_left, new_code, dbg_state}, {3'b000, 3'd3, 4'b0110, 3'd0});
        else pass_cnt++;
        tick(2);
        Resetn = 1'b1;
        tick();
    endtask

    task automatic test_unlock();
        submit(4'b0110, 1'b0);
        chk_cnt++;
        if ({unlocked, tries_left} !== {1'b1, 3'd3})
            $display("FAIL unlock: got %b required %b", {unlocked, tries_left}, {1'b1, 3'd3});
        else pass_cnt++;
        tick();
        submit(4'b1111, 1'b0);
        chk_cnt++;
        if (unlocked !== 1'b0) $display("FAIL relock: got %b required 0", unlocked);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_lockout();
        int cnt = 0;
        submit(4'b0001, 1'b0);
        chk_cnt++;
        if (tries_left !== 3'd2) $display("FAIL wrong_1: got %0d required 2", tries_left);
        else pass_cnt++;
        tick();
        submit(4'b0001, 1'b0);
        chk_cnt++;
        if (tries_left !== 3'd1) $display("FAIL wrong_2: got %0d required 1", tries_left);
        else pass_cnt++;
        tick();
        submit(4'b0001, 1'b0);
        chk_cnt++;
        if ({alarm, tries_left} !== {1'b1, 3'd0})
            $display("FAIL lockout_entry: got %b required %b", {alarm, tries_left}, {1'b1, 3'd0});
        else pass_cnt++;
        entry = combo;
        while (alarm === 1'b1 && cnt < 200) begin
            cnt++;
            enter = ~enter;
            tick();
        end
        enter = 1'b0;
        chk_cnt++;
        if (cnt != LOCKOUT_CYCLES) $display("FAIL alarm_duration: got %0d required %0d", cnt, LOCKOUT_CYCLES);
        else pass_cnt++;
        chk_cnt++;
        if ({unlocked, alarm, tries_left} !== {2'b00, 3'd3})
            $display("FAIL lockout_exit: got %b required %b", {unlocked, alarm, tries_left}, {2'b00, 3'd3});
        else pass_cnt++;
        tick();
    endtask

    task automatic test_change();
        submit(4'b0110, 1'b0);
        tick();
        submit(4'b1010, 1'b1);
        chk_cnt++;
        if ({unlocked, set_out, new_code} !== {2'b10, 4'b1010})
            $display("FAIL chg_setup: got %b required %b", {unlocked, set_out, new_code}, {2'b10, 4'b1010});
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (set_out !== 1'b1) $display("FAIL set_out_pulse: got %b required 1", set_out);
        else pass_cnt++;
        entry = 4'b0101; change_req = 1'b0; enter = 1'b1;
        tick();
        chk_cnt++;
        if ({unlocked, set_out, new_code, combo} !== {2'b10, 4'b1010, 4'b1010})
            $display("FAIL after_strobe: got %b required %b", {unlocked, set_out, new_code, combo}, {2'b10, 4'b1010, 4'b1010});
        else pass_cnt++;
        enter = 1'b0;
        tick();
        submit(4'b0000, 1'b0);
        tick();
        submit(4'b0110, 1'b0);
        chk_cnt++;
        if ({unlocked, tries_left} !== {1'b0, 3'd2})
            $display("FAIL old_code_rejected: got %b required %b", {unlocked, tries_left}, {1'b0, 3'd2});
        else pass_cnt++;
        tick();
        submit(4'b1010, 1'b0);
        chk_cnt++;
        if ({unlocked, tries_left} !== {1'b1, 3'd3})
            $display("FAIL new_code_accepted: got %b required %b", {unlocked, tries_left}, {1'b1, 3'd3});
        else pass_cnt++;
        tick();
        submit(4'b0000, 1'b0);
        tick();
    endtask

    task automatic test_held_enter();
        entry = 4'b0011; change_req = 1'b0; enter = 1'b1;
        tick(10);
        enter = 1'b0;
        tick();
        chk_cnt++;
        if ({unlocked, tries_left} !== {1'b0, 3'd2})
            $display("FAIL held_enter_once: got %b required %b", {unlocked, tries_left}, {1'b0, 3'd2});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        submit(4'b0000, 1'b0);
        tick();
        submit(4'b0000, 1'b0);
        chk_cnt++;
        if (alarm !== 1'b1) $display("FAIL second_lockout: got %b required 1", alarm);
        else pass_cnt++;
        tick(3);
        #2 Resetn = 1'b0;
        #1;
        chk_cnt++;
        if ({unlocked, alarm, set_out, tries_left, new_code} !== {3'b000, 3'd3, 4'b0110})
            $display("FAIL reset_in_lockout: got %b required %b",
                     {unlocked, alarm, set_out, tries_left, new_code}, {3'b000, 3'd3, 4'b0110});
        else pass_cnt++;
        tick(2);
        Resetn = 1'b1;
        tick();
        submit(4'b0110, 1'b0);
        tick();
        submit(4'b0011, 1'b1);
        chk_cnt++;
        if ({unlocked, set_out, new_code} !== {2'b10, 4'b0011})
            $display("FAIL chg_before_reset: got %b required %b", {unlocked, set_out, new_code}, {2'b10, 4'b0011});
        else pass_cnt++;
        #2 Resetn = 1'b0;
        #1;
        chk_cnt++;
        if ({unlocked, alarm, set_out, tries_left, new_code} !== {3'b000, 3'd3, 4'b0110})
            $display("FAIL reset_in_change: got %b required %b",
                     {unlocked, alarm, set_out, tries_left, new_code}, {3'b000, 3'd3, 4'b0110});
        else pass_cnt++;
        tick(2);
        Resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (set_out === 1'b1) pulses++;
        end
        chk_cnt++;
        if (pulses != 0 || combo !== 4'b0110)
            $display("FAIL no_strobe_after_reset: got pulses=%0d combo=%b required pulses=0 combo=0110", pulses, combo);
        else pass_cnt++;
    endtask

    task automatic test_enter_across_reset();
        Resetn = 1'b0;
        entry = 4'b0110; change_req = 1'b0; enter = 1'b1;
        tick(2);
        Resetn = 1'b1;
        tick();
        chk_cnt++;
        if (unlocked !== 1'b1) $display("FAIL enter_across_reset: got %b required 1", unlocked);
        else pass_cnt++;
        enter = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_lockout();
        test_change();
        test_held_enter();
        test_reset_mid();
        test_enter_across_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
